calc_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 4-bit calculator ALU. Each requester presents a 14-bit calculator command with a request/acknowledge handshake. The block grants one requester at a time, drives the registered opcode into the combinational ALU and captures the ALU result. It returns the result to the winner with a one-cycle acknowledge. The block sits between the command sources and the single ALU instance, which it owns exclusively.

---
 rtl/calc_arbiter_if.sv | 24 ++
 rtl/calc_arbiter.sv | 96 +++++++++
 tb/tb_calc_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_arbiter_if.sv
// Requester/ALU-side bundle for calc_arbiter: two req/cmd/ack channels, shared result, ALU opcode/result pair.
// The arbiter uses the slave view; command sources and the ALU together form the master view.
interface calc_arbiter_if;
    logic        req0;
    logic [13:0] cmd0;
    logic        req1;
    logic [13:0] cmd1;
    logic        ack0;
    logic        ack1;
    logic [3:0]  res;
    logic        busy;
    logic [13:0] opcode_o;
    logic [3:0]  z_i;

    modport slave (
        input  req0, cmd0, req1, cmd1, z_i,
        output ack0, ack1, res, busy, opcode_o
    );

    modport master (
        output req0, cmd0, req1, cmd1, z_i,
        input  ack0, ack1, res, busy, opcode_o
    );
endinterface

// File: rtl/calc_arbiter.sv
// Round-robin arbiter/sequencer for the shared 4-bit ALU: grant -> exec -> done, one command per 3 cycles.
// Request-to-ack is 2 cycles; requesters hold req/cmd until their one-cycle ack.
module calc_arbiter (
    input  logic          clk,
    input  logic          rst,
    calc_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_grant;
    logic        w_capture;
    logic        w_any_req;
    logic        w_pick1;
    logic        r_last;
    logic        r_win;
    logic [13:0] r_opcode;
    logic [3:0]  r_res;
    logic        r_ack0;
    logic        r_ack1;
    logic        w_unused_cmd_lsbs;

    assign w_any_req = bus.req0 | bus.req1;
    // On a tie the requester that was not granted last wins.
    assign w_pick1   = bus.req1 & (~bus.req0 | ~r_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_grant      = 1'b1;
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_capture    = 1'b1;
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last   <= 1'b1;
            r_win    <= 1'b0;
            r_opcode <= 14'h0;
            r_res    <= 4'h0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            if (w_grant) begin
                r_opcode <= {(w_pick1 ? bus.cmd1[13:4] : bus.cmd0[13:4]), 4'b0000};
                r_win    <= w_pick1;
                r_last   <= w_pick1;
            end
            if (w_capture) begin
                r_res  <= bus.z_i;
                r_ack0 <= ~r_win;
                r_ack1 <= r_win;
            end
        end
    end

    // Low command nibbles carry no meaning for the ALU.
    assign w_unused_cmd_lsbs = ^{bus.cmd0[3:0], bus.cmd1[3:0]};

    assign bus.opcode_o = r_opcode;
    assign bus.res      = r_res;
    assign bus.ack0     = r_ack0;
    assign bus.ack1     = r_ack1;
    assign bus.busy     = (r_state != ST_IDLE);
endmodule

// File: tb/tb_calc_arbiter.sv
// Self-checking bench for calc_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_calc_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    calc_arbiter_if bus();

    calc_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vec_cnt     = 0;
    int miscompares = 0;
    int cyc         = 0;

    function automatic logic [3:0] ref_result(input logic [13:0] c);
        int a, b, r;
        a = int'(c[11:8]);
        b = int'(c[7:4]);
        case (c[13:12])
            2'd0:    r = a + b;
            2'd1:    r = a - b + 16;
            2'd2:    r = a | b;
            default: r = 16 - a;
        endcase
        return 4'(r % 16);
    endfunction

    // Behavioural ALU stub driven from the registered opcode.
    assign bus.z_i = ref_result(bus.opcode_o);

    // Transaction model: grant edge, ack edge and the first edge at which a new grant may happen.
    int          m_free       = 0;
    int          m_busy_until = 0;
    int          m_ack_cyc    = -1;
    logic        m_win        = 1'b0;
    logic        m_last       = 1'b1;
    logic [3:0]  m_res        = 4'h0;
    logic [3:0]  m_pend       = 4'h0;
    logic [13:0] m_op         = 14'h0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_edge();
        logic [13:0] c;
        cyc++;
        if (rst) begin
            m_free       = cyc + 1;
            m_busy_until = cyc;
            m_ack_cyc    = -1;
            m_res        = 4'h0;
            m_op         = 14'h0;
            m_last       = 1'b1;
        end else if (cyc >= m_free && (bus.req0 || bus.req1)) begin
            m_win        = (bus.req0 && bus.req1) ? !m_last : bus.req1;
            c            = m_win ? bus.cmd1 : bus.cmd0;
            m_op         = {c[13:4], 4'b0000};
            m_pend       = ref_result(c);
            m_ack_cyc    = cyc + 1;
            m_busy_until = cyc + 2;
            m_free       = cyc + 3;
            m_last       = m_win;
        end else if (cyc == m_ack_cyc) begin
            m_res = m_pend;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("ack0",   bus.ack0,     (cyc == m_ack_cyc) && !m_win);
        chk("ack1",   bus.ack1,     (cyc == m_ack_cyc) &&  m_win);
        chk("res",    bus.res,      m_res);
        chk("busy",   bus.busy,     cyc < m_busy_until);
        chk("opcode", bus.opcode_o, m_op);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic run_single(input int n, input logic [13:0] c, input logic [3:0] exp_res, input string tag);
        int waited    = 0;
        int busy_cnt  = 0;
        logic got_ack = 1'b0;
        if (n == 0) begin bus.req0 = 1'b1; bus.cmd0 = c; end
        else        begin bus.req1 = 1'b1; bus.cmd1 = c; end
        while (!got_ack && waited < 10) begin
            cycle();
            waited++;
            if (bus.busy) busy_cnt++;
            got_ack = (n == 0) ? bus.ack0 : bus.ack1;
        end
        chk({tag, "_latency"}, waited, 2);
        chk({tag, "_res"}, bus.res, exp_res);
        chk({tag, "_other_ack"}, (n == 0) ? bus.ack1 : bus.ack0, 0);
        if (n == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
        cycle();
        if (bus.busy) busy_cnt++;
        chk({tag, "_busy_cycles"}, busy_cnt, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_who[$];
        int ack_at[$];
        int waited;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.cmd0 = 14'h0;
        bus.cmd1 = 14'h0;

        // Reset state
        rst = 1'b1;
        cycle();
        cycle();
        chk("rst_busy", bus.busy, 0);
        chk("rst_opcode", bus.opcode_o, 0);
        rst = 1'b0;

        // Single command and arithmetic sweep
        run_single(0, 14'h0530, 4'h8, "add5_3");
        run_single(1, 14'h1350, 4'hE, "sub3_5");
        run_single(1, 14'h2A50, 4'hF, "orA_5");
        run_single(1, 14'h3100, 4'hF, "neg1");
        run_single(1, 14'h0990, 4'h2, "add9_9");

        // Both held from reset, new commands on every ack
        do_reset();
        bus.req0 = 1'b1; bus.cmd0 = 14'($urandom);
        bus.req1 = 1'b1; bus.cmd1 = 14'($urandom);
        waited = 0;
        while (ack_who.size() < 4 && waited < 40) begin
            cycle();
            waited++;
            if (bus.ack0) begin ack_who.push_back(0); ack_at.push_back(cyc); bus.cmd0 = 14'($urandom); end
            if (bus.ack1) begin ack_who.push_back(1); ack_at.push_back(cyc); bus.cmd1 = 14'($urandom); end
        end
        chk("alt_ack_count", ack_who.size(), 4);
        for (int i = 0; i < ack_who.size(); i++) begin
            chk("alt_order", ack_who[i], i % 2);
            if (i > 0) chk("alt_gap", ack_at[i] - ack_at[i-1], 3);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        cycle(); cycle();

        // Back-to-back on requester 0
        ack_at.delete();
        bus.req0 = 1'b1; bus.cmd0 = 14'($urandom);
        waited = 0;
        while (ack_at.size() < 4 && waited < 40) begin
            cycle();
            waited++;
            if (bus.ack0) begin ack_at.push_back(cyc); bus.cmd0 = 14'($urandom); end
        end
        chk("b2b_ack_count", ack_at.size(), 4);
        for (int i = 1; i < ack_at.size(); i++) chk("b2b_gap", ack_at[i] - ack_at[i-1], 3);
        bus.req0 = 1'b0;
        cycle(); cycle();

        // Reset during EXEC of ADD 7+7
        bus.req0 = 1'b1; bus.cmd0 = 14'h0770;
        cycle();
        chk("exec_busy", bus.busy, 1);
        rst = 1'b1;
        cycle();
        chk("rstexec_ack0", bus.ack0, 0);
        chk("rstexec_res", bus.res, 0);
        chk("rstexec_opcode", bus.opcode_o, 0);
        chk("rstexec_busy", bus.busy, 0);
        rst = 1'b0;
        bus.req1 = 1'b1; bus.cmd1 = 14'h0110;
        waited = 0;
        while (!(bus.ack0 || bus.ack1) && waited < 10) begin
            cycle();
            waited++;
        end
        chk("rstexec_tie_ack0", bus.ack0, 1);
        chk("rstexec_tie_ack1", bus.ack1, 0);
        chk("rstexec_tie_res", bus.res, 4'hE);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        do_reset();

        // Stability: cmd1 changes while requester 0 is served
        bus.req0 = 1'b1; bus.cmd0 = 14'h0230;
        cycle();
        bus.req1 = 1'b1; bus.cmd1 = 14'h0FF0;
        cycle();
        chk("stab_ack0", bus.ack0, 1);
        chk("stab_res0", bus.res, 4'h5);
        bus.req0 = 1'b0; bus.cmd1 = 14'h0120;
        cycle();
        cycle();
        cycle();
        chk("stab_ack1", bus.ack1, 1);
        chk("stab_res1", bus.res, 4'h3);
        bus.req1 = 1'b0;
        cycle();

        // Random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cycle();
            rst = ($urandom_range(0, 99) == 0);
            if (bus.ack0) begin
                if ($urandom_range(0, 1) == 1) bus.cmd0 = 14'($urandom);
                else bus.req0 = 1'b0;
            end else if (!bus.req0 && $urandom_range(0, 2) == 0) begin
                bus.req0 = 1'b1; bus.cmd0 = 14'($urandom);
            end
            if (bus.ack1) begin
                if ($urandom_range(0, 1) == 1) bus.cmd1 = 14'($urandom);
                else bus.req1 = 1'b0;
            end else if (!bus.req1 && $urandom_range(0, 2) == 0) begin
                bus.req1 = 1'b1; bus.cmd1 = 14'($urandom);
            end
        end
        rst = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        cycle(); cycle(); cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end
endmodule
